// File: rtl/vga_framebuffer_scanout_if.sv
// Video scanout bundle: framebuffer read port plus the registered VGA outputs.
// The scanout block is the master; the memory and the display side are the slave.
interface vga_framebuffer_scanout_if #(
    parameter int WIDTH = 8,
    parameter int ADDRW = 15
);
    logic             re;
    logic [ADDRW-1:0] addr_read;
    logic [WIDTH-1:0] data_read;
    logic [WIDTH-1:0] pixel;
    logic             de;
    logic             hsync;
    logic             vsync;
    logic             frame_start;

    modport master (
        output re, addr_read, pixel, de, hsync, vsync, frame_start,
        input  data_read
    );

    modport slave (
        input  re, addr_read, pixel, de, hsync, vsync, frame_start,
        output data_read
    );
endinterface

// File: rtl/vga_framebuffer_scanout.sv
// VGA timing generator and framebuffer reader with integer upscaling.
// Addresses are built incrementally from row_base + x_idx; outputs are registered one enabled cycle after the counters.
module vga_framebuffer_scanout #(
    parameter int WIDTH         = 8,
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int SCALE         = 4,
    parameter int FB_W          = 160,
    parameter int FB_H          = 120,
    parameter int SYNC_POLARITY = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    vga_framebuffer_scanout_if.master   vid
);
    localparam int ADDRW   = $clog2(FB_W * FB_H);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int XW      = (FB_W > 1) ? $clog2(FB_W) : 1;

    localparam logic [HW-1:0]    H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0]    H_ALAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0]    H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]    H_SS    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]    H_SE    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]    V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0]    V_ALAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0]    V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]    V_SS    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]    V_SE    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0]    S_LAST  = SW'(SCALE - 1);
    localparam logic [ADDRW-1:0] ROW_INC = ADDRW'(FB_W);
    localparam logic             SP      = (SYNC_POLARITY != 0);

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic [SW-1:0]    sub_x;
    logic [SW-1:0]    sub_y;
    logic [XW-1:0]    x_idx;
    logic [ADDRW-1:0] row_base;

    logic             h_act;
    logic             active;
    logic             hsync_on;
    logic             vsync_on;

    logic [WIDTH-1:0] pixel_q;
    logic             de_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             frame_start_q;

    always_comb begin
        h_act    = (h_cnt < H_ACT);
        active   = h_act && (v_cnt < V_ACT);
        hsync_on = (h_cnt >= H_SS) && (h_cnt < H_SE);
        vsync_on = (v_cnt >= V_SS) && (v_cnt < V_SE);
    end

    // The last active pixel and last active line park x_idx/row_base at 0, so the
    // address never runs past the framebuffer during blanking.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            sub_x    <= '0;
            sub_y    <= '0;
            x_idx    <= '0;
            row_base <= '0;
        end else if (clk_en) begin
            if (h_act) begin
                if (h_cnt == H_ALAST) begin
                    sub_x <= '0;
                    x_idx <= '0;
                end else if (sub_x == S_LAST) begin
                    sub_x <= '0;
                    x_idx <= x_idx + XW'(1);
                end else begin
                    sub_x <= sub_x + SW'(1);
                end
            end
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                sub_x <= '0;
                x_idx <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt    <= '0;
                    row_base <= '0;
                    sub_y    <= '0;
                end else begin
                    v_cnt <= v_cnt + VW'(1);
                    if (v_cnt == V_ALAST) begin
                        row_base <= '0;
                        sub_y    <= '0;
                    end else if (v_cnt < V_ACT) begin
                        if (sub_y == S_LAST) begin
                            sub_y    <= '0;
                            row_base <= row_base + ROW_INC;
                        end else begin
                            sub_y <= sub_y + SW'(1);
                        end
                    end
                end
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_q       <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~SP;
            vsync_q       <= ~SP;
            frame_start_q <= 1'b0;
        end else if (clk_en) begin
            pixel_q       <= active ? vid.data_read : '0;
            de_q          <= active;
            hsync_q       <= hsync_on ? SP : ~SP;
            vsync_q       <= vsync_on ? SP : ~SP;
            frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign vid.re          = active;
    assign vid.addr_read   = row_base + ADDRW'(x_idx);
    assign vid.pixel       = pixel_q;
    assign vid.de          = de_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_framebuffer_scanout.sv
// Directed bench: a full-size 640x480 instance for line-level checks and two reduced
// 24x12-total instances (both sync polarities) for whole-frame checks.
module tb_vga_framebuffer_scanout;
    logic clk;
    logic rst;
    logic clk_en;
    logic force_d;

    int n_vec  = 0;
    int n_err  = 0;
    int t      = 0;
    int last_fs = 1;
    int n_fs   = 0;

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance, memory returns addr[7:0] (or all ones when forced)
    vga_framebuffer_scanout_if #(.WIDTH(8), .ADDRW(15)) ifd ();
    assign ifd.data_read = force_d ? 8'hFF : ifd.addr_read[7:0];

    vga_framebuffer_scanout dut_d (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .vid    (ifd.master)
    );

    // Reduced instances: 16x8 active, H total 24, V total 12, FB 4x2, SCALE 4
    vga_framebuffer_scanout_if #(.WIDTH(8), .ADDRW(3)) ifs ();
    vga_framebuffer_scanout_if #(.WIDTH(8), .ADDRW(3)) ifp ();
    assign ifs.data_read = {5'b0, ifs.addr_read};
    assign ifp.data_read = {5'b0, ifp.addr_read};

    vga_framebuffer_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SCALE(4), .FB_W(4), .FB_H(2), .SYNC_POLARITY(0)
    ) dut_s (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .vid    (ifs.master)
    );

    vga_framebuffer_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SCALE(4), .FB_W(4), .FB_H(2), .SYNC_POLARITY(1)
    ) dut_p (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .vid    (ifp.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at tick %0d: got %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // Driver: one enabled clock; outputs then reflect position t-1, address reflects t
    task automatic tick();
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle();
        clk_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic loop_checks();
        // full-size: line 0 end, blanking, hsync edges, line 1 and line 4 starts
        if (t == 640) begin
            check("d_last_px_line0", ifd.pixel, 32'd159);
            check("d_re_blank", ifd.re, 1'b0);
            check("d_addr_blank", ifd.addr_read, 32'd0);
        end
        if (t == 641) begin
            check("d_de_blank", ifd.de, 1'b0);
            check("d_pixel_blank_forced", ifd.pixel, 32'd0);
        end
        if (t == 799) check("d_pixel_blank_end", ifd.pixel, 32'd0);
        if (t == 656) check("d_hsync_pre", ifd.hsync, 1'b1);
        if (t == 657) check("d_hsync_start", ifd.hsync, 1'b0);
        if (t == 752) check("d_hsync_last", ifd.hsync, 1'b0);
        if (t == 753) check("d_hsync_end", ifd.hsync, 1'b1);
        if (t == 801) begin
            check("d_line1_de", ifd.de, 1'b1);
            check("d_line1_px0", ifd.pixel, 32'd0);
            check("d_fs_low", ifd.frame_start, 1'b0);
        end
        if (t == 805) check("d_line1_px4", ifd.pixel, 32'd1);
        if (t == 3201) begin
            check("d_line4_px0", ifd.pixel, 32'd160);
            check("d_line4_de", ifd.de, 1'b1);
            check("d_vsync_idle", ifd.vsync, 1'b1);
        end
        // reduced: syncs, last active pixel, address bound, frame period
        if (t == 18) begin
            check("s_hsync_pre", ifs.hsync, 1'b1);
            check("p_hsync_pre", ifp.hsync, 1'b0);
        end
        if (t == 19) begin
            check("s_hsync_start", ifs.hsync, 1'b0);
            check("p_hsync_start", ifp.hsync, 1'b1);
        end
        if (t == 21) begin
            check("s_hsync_last", ifs.hsync, 1'b0);
            check("p_hsync_last", ifp.hsync, 1'b1);
        end
        if (t == 22) begin
            check("s_hsync_end", ifs.hsync, 1'b1);
            check("p_hsync_end", ifp.hsync, 1'b0);
        end
        if (t == 97) check("s_line4_px0", ifs.pixel, 32'd4);
        if (t == 183) check("s_addr_last", ifs.addr_read, 32'd7);
        if (t == 184) begin
            check("s_last_px", ifs.pixel, 32'd7);
            check("s_last_de", ifs.de, 1'b1);
        end
        if (t == 185) check("s_after_last_de", ifs.de, 1'b0);
        if (t == 216) check("s_vsync_pre", ifs.vsync, 1'b1);
        if (t == 217) begin
            check("s_vsync_start", ifs.vsync, 1'b0);
            check("p_vsync_start", ifp.vsync, 1'b1);
        end
        if (t == 264) check("s_vsync_last", ifs.vsync, 1'b0);
        if (t == 265) begin
            check("s_vsync_end", ifs.vsync, 1'b1);
            check("p_vsync_end", ifp.vsync, 1'b0);
        end
        check("s_addr_bound", (ifs.addr_read > 3'd7) || (ifs.addr_read === 3'bx), 1'b0);
        if (ifs.frame_start === 1'b1) begin
            n_fs++;
            check("s_frame_period", t - last_fs, 32'd288);
            last_fs = t;
        end
    endtask

    initial begin
        rst     = 1'b1;
        clk_en  = 1'b1;
        force_d = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // reset state, with clk_en high to show rst wins
        check("rst_d_de", ifd.de, 1'b0);
        check("rst_d_pixel", ifd.pixel, 32'd0);
        check("rst_d_fs", ifd.frame_start, 1'b0);
        check("rst_d_hsync", ifd.hsync, 1'b1);
        check("rst_d_vsync", ifd.vsync, 1'b1);
        check("rst_d_addr", ifd.addr_read, 32'd0);
        check("rst_p_hsync", ifp.hsync, 1'b0);
        check("rst_p_vsync", ifp.vsync, 1'b0);
        rst = 1'b0;

        // half-rate enable: each enabled output re-checked across the following idle cycle
        for (int i = 0; i < 8; i++) begin
            tick();
            check("hr_pixel", ifd.pixel, (t - 1) / 4);
            check("hr_de", ifd.de, 1'b1);
            check("hr_fs", ifd.frame_start, (t == 1));
            check("hr_fs_s", ifs.frame_start, (t == 1));
            idle();
            check("hr_hold_pixel", ifd.pixel, (t - 1) / 4);
            check("hr_hold_fs", ifd.frame_start, (t == 1));
            check("hr_hold_hsync", ifd.hsync, 1'b1);
        end

        while (t < 3202) begin
            force_d = ((t % 800) >= 640);
            tick();
            loop_checks();
        end
        force_d = 1'b0;
        check("s_frame_count", n_fs, 32'd11);

        // mid-line reset (reduced instance sits at h=10, v=1)
        rst = 1'b1;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_s_addr", ifs.addr_read, 32'd0);
        check("mrst_d_addr", ifd.addr_read, 32'd0);
        check("mrst_d_hsync", ifd.hsync, 1'b1);
        check("mrst_d_vsync", ifd.vsync, 1'b1);
        check("mrst_p_hsync", ifp.hsync, 1'b0);
        check("mrst_s_de", ifs.de, 1'b0);
        rst = 1'b0;
        t = 0;
        tick();
        check("mrst_s_fs", ifs.frame_start, 1'b1);
        check("mrst_d_fs", ifd.frame_start, 1'b1);
        check("mrst_s_px0", ifs.pixel, 32'd0);
        check("mrst_s_de1", ifs.de, 1'b1);
        repeat (4) tick();
        check("mrst_s_px4", ifs.pixel, 32'd1);
        check("mrst_d_px4", ifd.pixel, 32'd1);
        check("mrst_s_fs_off", ifs.frame_start, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
